// File: rtl/barcode_pkg.sv
// Shared types and helpers for the barcode sequencer: FSM states, widths and
// the bit-to-sink-code mapping.
package barcode_pkg;
   localparam int CODE_W = 4;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      TAIL  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   // A set symbol bit (after optional inversion) sinks the frame's code.
   function automatic logic [CODE_W-1:0] bit_code(input logic             b,
                                                  input logic             inv,
                                                  input logic [CODE_W-1:0] code);
      return (b ^ inv) ? code : '0;
   endfunction
endpackage

// File: rtl/barcode_fifo.sv
// Synchronous show-ahead FIFO holding {last, data} symbol bytes; flush empties it
// in one cycle.
module barcode_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr;
   logic [AW:0]      r_rd;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign o_empty   = (r_wr == r_rd);
   assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_dout    = r_mem[r_rd[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr <= '0;
         r_rd <= '0;
      end else if (i_flush) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + 1'b1;
         if (w_do_pop)  r_rd <= r_rd + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) r_mem[r_wr[AW-1:0]] <= i_din;
   end
endmodule

// File: rtl/barcode_seq.sv
// Serialises buffered symbol bytes MSB-first into a registered 4-bit sink-enable
// code, one bit per programmable bit-time, with a quiet-zone tail and underrun drain.
module barcode_seq
   import barcode_pkg::*;
#(
   parameter int PERIOD_W   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_en,
   input  logic [CODE_W-1:0]   cfg_code,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic                cfg_invert,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [BYTE_W-1:0]   s_data,
   input  logic                s_last,
   output logic [CODE_W-1:0]   ng_en,
   output logic                busy,
   output logic                done,
   output logic                underrun
);
   state_e              r_state, w_state_nxt;
   logic [PERIOD_W-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]          r_idx, w_idx_nxt;
   logic [2:0]          w_idx_m1;
   logic [CODE_W-1:0]   r_ng, w_ng_nxt;
   logic                r_done, w_done_nxt;
   logic                r_underrun, w_underrun_set;
   logic [CODE_W-1:0]   r_code_q;
   logic [PERIOD_W-1:0] r_period_q;
   logic                r_inv_q;
   logic [BYTE_W-1:0]   r_data_q;
   logic                r_last_q;
   logic                w_pop, w_load, w_frame_load;
   logic                w_push, w_full, w_empty;
   logic [BYTE_W:0]     w_dout;
   logic [BYTE_W-1:0]   w_byte;
   logic                w_blast;
   logic                w_bit_end;

   assign s_ready   = cfg_en && !rst && !w_full && (r_state != DRAIN);
   assign w_push    = s_valid && s_ready;
   assign w_byte    = w_dout[BYTE_W-1:0];
   assign w_blast   = w_dout[BYTE_W];
   assign w_idx_m1  = r_idx - 3'd1;
   assign w_bit_end = (r_cnt == r_period_q);

   assign ng_en    = r_ng;
   assign busy     = (r_state != IDLE);
   assign done     = r_done;
   assign underrun = r_underrun;

   barcode_fifo #(
      .WIDTH(BYTE_W + 1),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .i_flush(!cfg_en),
      .i_push (w_push),
      .i_din  ({s_last, s_data}),
      .i_pop  (w_pop && cfg_en),
      .o_dout (w_dout),
      .o_full (w_full),
      .o_empty(w_empty)
   );

   // Next-state values are computed so the output register lines up with the
   // state register: ng_en always reflects the bit the FSM is currently timing.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_idx_nxt      = r_idx;
      w_ng_nxt       = r_ng;
      w_done_nxt     = 1'b0;
      w_underrun_set = 1'b0;
      w_pop          = 1'b0;
      w_load         = 1'b0;
      w_frame_load   = 1'b0;
      case (r_state)
         IDLE: begin
            w_ng_nxt = '0;
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_load       = 1'b1;
               w_frame_load = 1'b1;
               w_idx_nxt    = 3'd7;
               w_cnt_nxt    = '0;
               w_ng_nxt     = bit_code(w_byte[BYTE_W-1], cfg_invert, cfg_code);
               w_state_nxt  = SHIFT;
            end
         end
         SHIFT: begin
            if (!w_bit_end) begin
               w_cnt_nxt = r_cnt + PERIOD_W'(1);
            end else begin
               w_cnt_nxt = '0;
               if (r_idx != 3'd0) begin
                  w_idx_nxt = w_idx_m1;
                  w_ng_nxt  = bit_code(r_data_q[w_idx_m1], r_inv_q, r_code_q);
               end else if (r_last_q) begin
                  w_ng_nxt    = '0;
                  w_state_nxt = TAIL;
               end else if (!w_empty) begin
                  w_pop     = 1'b1;
                  w_load    = 1'b1;
                  w_idx_nxt = 3'd7;
                  w_ng_nxt  = bit_code(w_byte[BYTE_W-1], r_inv_q, r_code_q);
               end else begin
                  w_underrun_set = 1'b1;
                  w_ng_nxt       = '0;
                  w_state_nxt    = DRAIN;
               end
            end
         end
         TAIL: begin
            w_ng_nxt = '0;
            if (w_bit_end) begin
               w_cnt_nxt   = '0;
               w_done_nxt  = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt + PERIOD_W'(1);
            end
         end
         DRAIN: begin
            w_ng_nxt = '0;
            if (w_empty) begin
               w_state_nxt = IDLE;
            end else begin
               w_pop = 1'b1;
               if (w_blast) w_state_nxt = IDLE;
            end
         end
         default: begin
            w_ng_nxt    = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_ng       <= '0;
         r_done     <= 1'b0;
         r_underrun <= 1'b0;
      end else if (!cfg_en) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_ng       <= '0;
         r_done     <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_ng    <= w_ng_nxt;
         r_done  <= w_done_nxt;
         if (w_underrun_set) r_underrun <= 1'b1;
      end
   end

   // Frame configuration is sampled only at frame start so mid-frame writes wait.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_code_q   <= '0;
         r_period_q <= '0;
         r_inv_q    <= 1'b0;
         r_data_q   <= '0;
         r_last_q   <= 1'b0;
      end else if (cfg_en) begin
         if (w_frame_load) begin
            r_code_q   <= cfg_code;
            r_period_q <= cfg_period;
            r_inv_q    <= cfg_invert;
         end
         if (w_load) begin
            r_data_q <= w_byte;
            r_last_q <= w_blast;
         end
      end
   end
endmodule
